// File: rtl/toaplan2_audio_pkg.sv
// Shared types and constants for the Toaplan 2 sound mixer.
// Holds the mix FSM states, the 4.4 gain format and the per-game default gain/pan settings.
package toaplan2_audio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      SAT  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [7:0] GAIN_UNITY = 8'h10;
   localparam int         GAIN_FRAC  = 4;

   // Truxton II: FM left/right on their own sides, OKI centred
   localparam logic [7:0] TRUXTON2_FM_GAIN  = 8'h10;
   localparam logic [7:0] TRUXTON2_OKI_GAIN = 8'h10;
   localparam logic [1:0] TRUXTON2_FM_L_PAN = 2'b01;
   localparam logic [1:0] TRUXTON2_FM_R_PAN = 2'b10;
   localparam logic [1:0] TRUXTON2_OKI_PAN  = 2'b11;

   // Gain plus the optional FX boost (level * 2), clamped to the largest 4.4 value
   function automatic logic [7:0] fx_gain(input logic [7:0] gain, input logic boost,
                                          input logic [1:0] level);
      logic [8:0] sum;
      sum = {1'b0, gain} + (boost ? {6'd0, level, 1'b0} : 9'd0);
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/toaplan2_audio_mixer_if.sv
// Sample bus between the sound chips/control logic (master) and the stereo mixer (slave).
interface toaplan2_audio_mixer_if #(
   parameter int NCH  = 4,
   parameter int W    = 16,
   parameter int WOUT = 16
);
   logic                   SAMPLE_IN;
   logic [NCH*W-1:0]       CH_IN;
   logic [NCH*8-1:0]       CH_GAIN;
   logic [NCH*2-1:0]       CH_PAN;
   logic [1:0]             FX_LEVEL;
   logic signed [WOUT-1:0] left;
   logic signed [WOUT-1:0] right;
   logic                   sample;
   logic                   busy;
   logic                   overrun;
   logic                   peak;

   modport master (
      output SAMPLE_IN, CH_IN, CH_GAIN, CH_PAN, FX_LEVEL,
      input  left, right, sample, busy, overrun, peak
   );

   modport slave (
      input  SAMPLE_IN, CH_IN, CH_GAIN, CH_PAN, FX_LEVEL,
      output left, right, sample, busy, overrun, peak
   );
endinterface

// File: rtl/toaplan2_audio_sat.sv
// Combinational signed narrower: clamps a WIN-bit value into WOUT bits and flags when it clamped.
module toaplan2_audio_sat #(
   parameter int WIN  = 27,
   parameter int WOUT = 16
) (
   input  logic signed [WIN-1:0]  din,
   output logic signed [WOUT-1:0] dout,
   output logic                   clip
);
   // In range exactly when every bit above the output sign bit matches it
   logic [WIN-WOUT:0] hi_bits;
   assign hi_bits = din[WIN-1:WOUT-1];

   always_comb begin
      clip = !((&hi_bits) || !(|hi_bits));
      dout = din[WOUT-1:0];
      if (clip) begin
         dout = din[WIN-1] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
      end
   end
endmodule

// File: rtl/toaplan2_audio_mixer.sv
// N-channel time-multiplexed stereo mixer: snapshot on SAMPLE_IN, one gain multiply per cycle,
// saturated stereo result with a sample pulse NCH+2 enabled cycles later and a held clip flag.
module toaplan2_audio_mixer
   import toaplan2_audio_pkg::*;
#(
   parameter int          NCH       = 4,
   parameter int          W         = 16,
   parameter int          WOUT      = 16,
   parameter logic [15:0] FX_MASK   = 16'h0002,
   parameter int          PEAK_HOLD = 1024
) (
   input logic                  CLK,
   input logic                  RESET,
   input logic                  CEN,
   toaplan2_audio_mixer_if.slave bus
);
   localparam int IDXW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int ACCW  = W + 9 + $clog2(NCH);
   localparam int SATW  = ACCW - GAIN_FRAC;
   localparam int HOLDW = $clog2(PEAK_HOLD + 1);

   state_t                 state;
   logic [IDXW-1:0]        idx;
   logic signed [ACCW-1:0] acc_l, acc_r;
   logic [HOLDW-1:0]       hold_cnt;

   logic signed [W-1:0]    snap   [NCH];
   logic [7:0]             gain_s [NCH];
   logic [1:0]             pan_s  [NCH];

   logic signed [WOUT-1:0] l_reg, r_reg;
   logic                   sample_reg, busy_reg, overrun_reg, peak_reg;

   logic signed [W+8:0]    prod;
   logic signed [WOUT-1:0] sat_l, sat_r;
   logic                   clip_l, clip_r;

   // Gain is unsigned, so it enters the signed multiply with a zero sign bit
   assign prod = (W+9)'(snap[idx]) * (W+9)'($signed({1'b0, gain_s[idx]}));

   toaplan2_audio_sat #(.WIN(SATW), .WOUT(WOUT)) u_sat_l (
      .din  (acc_l[ACCW-1:GAIN_FRAC]),
      .dout (sat_l),
      .clip (clip_l)
   );

   toaplan2_audio_sat #(.WIN(SATW), .WOUT(WOUT)) u_sat_r (
      .din  (acc_r[ACCW-1:GAIN_FRAC]),
      .dout (sat_r),
      .clip (clip_r)
   );

   always_ff @(posedge CLK) begin
      if (CEN && state == IDLE && bus.SAMPLE_IN) begin
         for (int n = 0; n < NCH; n++) begin
            snap[n]   <= bus.CH_IN[n*W +: W];
            gain_s[n] <= fx_gain(bus.CH_GAIN[n*8 +: 8], FX_MASK[n], bus.FX_LEVEL);
            pan_s[n]  <= bus.CH_PAN[n*2 +: 2];
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         idx         <= '0;
         acc_l       <= '0;
         acc_r       <= '0;
         hold_cnt    <= '0;
         l_reg       <= '0;
         r_reg       <= '0;
         sample_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
         peak_reg    <= 1'b0;
      end else if (CEN) begin
         overrun_reg <= bus.SAMPLE_IN && (state != IDLE);
         sample_reg  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.SAMPLE_IN) begin
                  acc_l    <= '0;
                  acc_r    <= '0;
                  idx      <= '0;
                  busy_reg <= 1'b1;
                  state    <= ACC;
               end
            end
            ACC: begin
               if (pan_s[idx][0]) acc_l <= acc_l + ACCW'(prod);
               if (pan_s[idx][1]) acc_r <= acc_r + ACCW'(prod);
               if (idx == IDXW'(NCH - 1)) state <= SAT;
               else                        idx   <= idx + IDXW'(1);
            end
            SAT: begin
               // Output registers load here so they are valid during the OUT cycle
               l_reg      <= sat_l;
               r_reg      <= sat_r;
               sample_reg <= 1'b1;
               busy_reg   <= 1'b0;
               if (clip_l || clip_r) begin
                  hold_cnt <= HOLDW'(PEAK_HOLD);
                  peak_reg <= 1'b1;
               end else if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - HOLDW'(1);
                  if (hold_cnt == HOLDW'(1)) peak_reg <= 1'b0;
               end
               state <= OUT;
            end
            OUT:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.left    = l_reg;
   assign bus.right   = r_reg;
   assign bus.sample  = sample_reg;
   assign bus.busy    = busy_reg;
   assign bus.overrun = overrun_reg;
   assign bus.peak    = peak_reg;
endmodule

// File: tb/tb_toaplan2_audio_mixer.sv
// Directed bench for the stereo mixer: hand-computed mixes, FX clamp, overrun, peak hold, reset, CEN.
module tb_toaplan2_audio_mixer;
   logic CLK, RESET, CEN;
   int   n_chk, n_pass;
   int   ph, cen_div;
   int   res_l, res_r, res_pk, res_lat, res_clk, res_pulses, res_ovr;
   int   cnt;

   toaplan2_audio_mixer_if #(.NCH(4), .W(16), .WOUT(16)) bus ();

   toaplan2_audio_mixer #(
      .NCH(4), .W(16), .WOUT(16), .FX_MASK(16'h0002), .PEAK_HOLD(1024)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .CEN   (CEN),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance to the next falling edge and choose CEN for the cycle that starts there
   task automatic step();
      @(negedge CLK);
      ph  = (ph + 1) % cen_div;
      CEN = (ph == 0);
   endtask

   task automatic set_ch(input int n, input int dat, input logic [7:0] g, input logic [1:0] p);
      logic [15:0] d;
      d = dat[15:0];
      bus.CH_IN[n*16 +: 16] = d;
      bus.CH_GAIN[n*8 +: 8] = g;
      bus.CH_PAN[n*2 +: 2]  = p;
   endtask

   task automatic clear_ch();
      for (int n = 0; n < 4; n++) set_ch(n, 0, 8'h10, 2'b11);
   endtask

   task automatic stim_basic();
      set_ch(0, 100, 8'h10, 2'b11);
      set_ch(1, 200, 8'h10, 2'b11);
      set_ch(2, -50, 8'h10, 2'b11);
      set_ch(3, 0,   8'h10, 2'b11);
   endtask

   task automatic stim_clip();
      clear_ch();
      set_ch(0, 30000, 8'h10, 2'b01);
      set_ch(1, 30000, 8'h10, 2'b01);
   endtask

   task automatic stim_quiet();
      clear_ch();
      set_ch(0, 100, 8'h10, 2'b01);
   endtask

   // One mix over a window of 10 enabled cycles; optional second strobe and mid-mix input scramble
   task automatic run_mix(input int dup_at, input bit scramble);
      int  en, clk_n;
      bit  got, was_en;
      while (CEN !== 1'b1) step();
      bus.SAMPLE_IN = 1'b1;
      en = 0; clk_n = 0; got = 0;
      res_pulses = 0; res_ovr = 0;
      res_l = -99999; res_r = -99999; res_pk = -1; res_lat = -1; res_clk = -1;
      while (en < 10) begin
         was_en = CEN;
         step();
         clk_n++;
         if (was_en) begin
            en++;
            bus.SAMPLE_IN = (en == dup_at);
            if (scramble && en == 1) bus.CH_IN = {4{16'h7FFF}};
         end
         if (CEN) begin
            if (bus.overrun) res_ovr++;
            if (bus.sample) begin
               res_pulses++;
               if (!got) begin
                  got     = 1;
                  res_l   = bus.left;
                  res_r   = bus.right;
                  res_pk  = bus.peak;
                  res_lat = en;
                  res_clk = clk_n;
               end
            end
         end
      end
      bus.SAMPLE_IN = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; ph = 0; cen_div = 1;
      CEN = 1'b1; RESET = 1'b1;
      bus.SAMPLE_IN = 1'b0; bus.FX_LEVEL = 2'd0;
      bus.CH_IN = '0; bus.CH_GAIN = '0; bus.CH_PAN = '0;
      clear_ch();
      step(); step();
      chk("rst_left",    bus.left,    0);
      chk("rst_right",   bus.right,   0);
      chk("rst_sample",  bus.sample,  0);
      chk("rst_busy",    bus.busy,    0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_peak",    bus.peak,    0);
      RESET = 1'b0;
      step();

      stim_basic();
      run_mix(0, 0);
      chk("basic_left",   res_l, 250);
      chk("basic_right",  res_r, 250);
      chk("basic_lat",    res_lat, 6);
      chk("basic_pulses", res_pulses, 1);
      chk("basic_peak",   res_pk, 0);
      chk("basic_ovr",    res_ovr, 0);
      chk("basic_hold",   bus.left, 250);

      run_mix(0, 1);
      chk("snap_left",  res_l, 250);
      chk("snap_right", res_r, 250);
      stim_basic();

      run_mix(2, 0);
      chk("ovr_count",  res_ovr, 1);
      chk("ovr_pulses", res_pulses, 1);
      chk("ovr_left",   res_l, 250);
      chk("ovr_lat",    res_lat, 6);

      clear_ch(); bus.FX_LEVEL = 2'd3;
      set_ch(1, 16, 8'hFC, 2'b01);
      run_mix(0, 0);
      chk("fx_sat_left",  res_l, 255);
      chk("fx_sat_right", res_r, 0);

      clear_ch();
      set_ch(0, 16, 8'hFC, 2'b10);
      run_mix(0, 0);
      chk("fx_unmasked_right", res_r, 252);
      chk("fx_unmasked_left",  res_l, 0);

      clear_ch(); bus.FX_LEVEL = 2'd1;
      set_ch(1, 100,  8'h10, 2'b01);
      set_ch(2, -100, 8'h12, 2'b10);
      run_mix(0, 0);
      chk("fx1_left",      res_l, 112);
      chk("neg_shift_right", res_r, -113);
      bus.FX_LEVEL = 2'd0;

      clear_ch();
      set_ch(0, 1000, 8'h10, 2'b00);
      set_ch(1, 1000, 8'h00, 2'b11);
      set_ch(2, 50,   8'h10, 2'b10);
      run_mix(0, 0);
      chk("mute_left",  res_l, 0);
      chk("mute_right", res_r, 50);

      clear_ch();
      set_ch(0, -30000, 8'h10, 2'b10);
      set_ch(1, -30000, 8'h10, 2'b10);
      run_mix(0, 0);
      chk("negclip_right", res_r, -32768);
      chk("negclip_left",  res_l, 0);
      chk("negclip_peak",  res_pk, 1);

      stim_clip();
      run_mix(0, 0);
      chk("clip_left",  res_l, 32767);
      chk("clip_right", res_r, 0);
      chk("clip_peak",  res_pk, 1);
      stim_quiet();
      cnt = 0;
      for (int i = 1; i < 500; i++) begin
         run_mix(0, 0);
         if (res_pk == 0) cnt++;
      end
      chk("hold_first_low", cnt, 0);
      stim_clip();
      run_mix(0, 0);
      chk("restart_peak", res_pk, 1);
      stim_quiet();
      cnt = 0;
      for (int i = 1; i < 1024; i++) begin
         run_mix(0, 0);
         if (res_pk == 1) cnt++;
      end
      chk("hold_high_count", cnt, 1023);
      run_mix(0, 0);
      chk("peak_release", res_pk, 0);
      chk("quiet_left",   res_l, 100);

      stim_clip();
      run_mix(0, 0);
      stim_basic();
      while (CEN !== 1'b1) step();
      bus.SAMPLE_IN = 1'b1;
      step();
      bus.SAMPLE_IN = 1'b0;
      step();
      chk("mid_busy", bus.busy, 1);
      #2 RESET = 1'b1;
      #1;
      chk("arst_left",   bus.left,   0);
      chk("arst_right",  bus.right,  0);
      chk("arst_peak",   bus.peak,   0);
      chk("arst_busy",   bus.busy,   0);
      chk("arst_sample", bus.sample, 0);
      step(); step();
      RESET = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.sample) cnt++;
      end
      chk("arst_no_pulse", cnt, 0);
      run_mix(0, 0);
      chk("post_rst_left", res_l, 250);
      chk("post_rst_lat",  res_lat, 6);

      cen_div = 4;
      run_mix(0, 0);
      chk("cen_left",   res_l, 250);
      chk("cen_right",  res_r, 250);
      chk("cen_lat",    res_lat, 6);
      chk("cen_clocks", res_clk, 24);
      chk("cen_pulses", res_pulses, 1);
      cen_div = 1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
